// File: rtl/frame_write_sequencer.sv
`timescale 1ns / 1ps
// frame_write_sequencer
// Runs engine 0 then (optionally) engine 1 once per frame request, handling their start
// and done handshakes and steering the active engine's write stream onto the single
// frame-buffer write port. One extra frame request can be queued while a frame is in flight.
module frame_write_sequencer #(
    parameter logic       OVERLAY_EN  = 1'b1,
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    output logic        e0_start,
    output logic        e1_start,
    input  logic        e0_start_ack,
    input  logic        e1_start_ack,
    input  logic        e0_done,
    input  logic        e1_done,
    output logic        e0_done_ack,
    output logic        e1_done_ack,
    input  logic [53:0] e0_dout,
    input  logic [53:0] e1_dout,
    input  logic        e0_valid,
    input  logic        e1_valid,
    output logic        e0_ready,
    output logic        e1_ready,
    output logic [53:0] wr_dout,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        timeout_err,
    output logic        overrun
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] St0Start = 3'd1;
    localparam logic [2:0] St0Run   = 3'd2;
    localparam logic [2:0] St0Ack   = 3'd3;
    localparam logic [2:0] St1Start = 3'd4;
    localparam logic [2:0] St1Run   = 3'd5;
    localparam logic [2:0] St1Ack   = 3'd6;
    localparam logic [2:0] StFin    = 3'd7;

    logic [2:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0] frame_count_q;
    logic        ack_expired;

    // The current START cycle is the ACK_TIMEOUT-th one without an acknowledge.
    assign ack_expired = ({1'b0, tmo_cnt_q} + 9'd1) >= {1'b0, ACK_TIMEOUT};

    // Next-state logic: frame sequencing, request queueing and sticky error flags.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        tmo_cnt_d     = (tmo_cnt_q == 8'hff) ? tmo_cnt_q : tmo_cnt_q + 8'd1;

        case (state_q)
            StIdle: begin
                if (frame_start || pending_q) begin
                    state_d   = St0Start;
                    tmo_cnt_d = 8'd0;
                    // Both a queued and a fresh request: run one, keep the other queued.
                    pending_d = frame_start && pending_q;
                end
            end
            St0Start: begin
                if (e0_start_ack) begin
                    state_d = St0Run;
                end else if (ack_expired) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end
            end
            St0Run: begin
                if (e0_done) state_d = St0Ack;
            end
            St0Ack: begin
                if (OVERLAY_EN) begin
                    state_d   = St1Start;
                    tmo_cnt_d = 8'd0;
                end else begin
                    state_d = StFin;
                end
            end
            St1Start: begin
                if (e1_start_ack) begin
                    state_d = St1Run;
                end else if (ack_expired) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                end
            end
            St1Run: begin
                if (e1_done) state_d = St1Ack;
            end
            St1Ack: begin
                state_d = StFin;
            end
            StFin: begin
                // The queued request (if any) is consumed here, freeing the slot for a
                // request arriving in this same cycle.
                pending_d = frame_start;
                if (pending_q) begin
                    state_d   = St0Start;
                    tmo_cnt_d = 8'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start && (state_q != StIdle) && (state_q != StFin)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= 8'd0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            if (state_q == StFin) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    // Handshake and status outputs decoded from registered state.
    always_comb begin
        e0_start    = (state_q == St0Start);
        e1_start    = (state_q == St1Start);
        e0_done_ack = (state_q == St0Ack);
        e1_done_ack = (state_q == St1Ack);
        busy        = (state_q != StIdle);
        frame_done  = (state_q == StFin);
        frame_count = frame_count_q;
        timeout_err = timeout_err_q;
        overrun     = overrun_q;
    end

    // Write-port mux: the running engine is connected straight through, no added latency.
    always_comb begin
        wr_dout  = e0_dout;
        wr_valid = 1'b0;
        e0_ready = 1'b0;
        e1_ready = 1'b0;
        if (state_q == St0Run) begin
            wr_valid = e0_valid;
            e0_ready = wr_ready;
        end else if (state_q == St1Run) begin
            wr_dout  = e1_dout;
            wr_valid = e1_valid;
            e1_ready = wr_ready;
        end
    end

endmodule

// File: tb/tb_frame_write_sequencer.sv
`timescale 1ns / 1ps
// Directed bench for frame_write_sequencer: dut_a has the overlay enabled, dut_b has it
// disabled; both use a 4-cycle start-ack timeout. Engines are small reactive models that
// ack one cycle after start and emit 64 words each.
module tb_frame_write_sequencer;

    localparam int NW = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic a_frame_start = 1'b0;
    logic b_frame_start = 1'b0;
    logic wr_ready = 1'b1;
    logic bp = 1'b0;
    logic [2:0] ack_en = 3'b111;

    // Engine index: 0 = dut_a engine 0, 1 = dut_a engine 1, 2 = dut_b engine 0.
    logic [2:0]  eng_start_ack = 3'b0;
    logic [2:0]  eng_valid = 3'b0;
    logic [2:0]  eng_done = 3'b0;
    logic [53:0] eng_dout [3];
    logic [2:0]  eng_start, eng_ready, eng_done_ack;

    logic a_e0_start, a_e1_start, a_e0_done_ack, a_e1_done_ack, a_e0_ready, a_e1_ready;
    logic [53:0] a_wr_dout;
    logic a_wr_valid, a_busy, a_frame_done, a_timeout_err, a_overrun;
    logic [15:0] a_frame_count;
    logic b_e0_start, b_e1_start, b_e0_done_ack, b_e1_done_ack, b_e0_ready, b_e1_ready;
    logic [53:0] b_wr_dout;
    logic b_wr_valid, b_busy, b_frame_done, b_timeout_err, b_overrun;
    logic [15:0] b_frame_count;

    assign eng_start    = {b_e0_start, a_e1_start, a_e0_start};
    assign eng_ready    = {b_e0_ready, a_e1_ready, a_e0_ready};
    assign eng_done_ack = {b_e0_done_ack, a_e1_done_ack, a_e0_done_ack};

    always #5 clock = ~clock;

    frame_write_sequencer #(.OVERLAY_EN(1'b1), .ACK_TIMEOUT(8'd4)) dut_a (
        .clock(clock), .reset(reset), .frame_start(a_frame_start),
        .e0_start(a_e0_start), .e1_start(a_e1_start),
        .e0_start_ack(eng_start_ack[0]), .e1_start_ack(eng_start_ack[1]),
        .e0_done(eng_done[0]), .e1_done(eng_done[1]),
        .e0_done_ack(a_e0_done_ack), .e1_done_ack(a_e1_done_ack),
        .e0_dout(eng_dout[0]), .e1_dout(eng_dout[1]),
        .e0_valid(eng_valid[0]), .e1_valid(eng_valid[1]),
        .e0_ready(a_e0_ready), .e1_ready(a_e1_ready),
        .wr_dout(a_wr_dout), .wr_valid(a_wr_valid), .wr_ready(wr_ready),
        .busy(a_busy), .frame_done(a_frame_done), .frame_count(a_frame_count),
        .timeout_err(a_timeout_err), .overrun(a_overrun)
    );

    frame_write_sequencer #(.OVERLAY_EN(1'b0), .ACK_TIMEOUT(8'd4)) dut_b (
        .clock(clock), .reset(reset), .frame_start(b_frame_start),
        .e0_start(b_e0_start), .e1_start(b_e1_start),
        .e0_start_ack(eng_start_ack[2]), .e1_start_ack(1'b0),
        .e0_done(eng_done[2]), .e1_done(1'b0),
        .e0_done_ack(b_e0_done_ack), .e1_done_ack(b_e1_done_ack),
        .e0_dout(eng_dout[2]), .e1_dout(54'd0),
        .e0_valid(eng_valid[2]), .e1_valid(1'b0),
        .e0_ready(b_e0_ready), .e1_ready(b_e1_ready),
        .wr_dout(b_wr_dout), .wr_valid(b_wr_valid), .wr_ready(wr_ready),
        .busy(b_busy), .frame_done(b_frame_done), .frame_count(b_frame_count),
        .timeout_err(b_timeout_err), .overrun(b_overrun)
    );

    // Word w of engine e: overlay engine writes the upper address half.
    function automatic logic [53:0] mkword(input int e, input int w);
        logic [16:0] addr;
        logic [31:0] pix;
        addr = (e == 1) ? 17'(65536 + w) : 17'(w);
        pix  = 32'(e * 1000 + w) ^ 32'hA5A5_0000;
        return {4'hF, 1'b0, addr, pix};
    endfunction

    // Engine models: sample at negedge, drive 1 ns after posedge.
    int eng_st [3];
    int eng_cnt [3];
    initial begin
        logic [2:0] s_start, s_ready, s_dack, s_valid;
        logic s_reset;
        for (int i = 0; i < 3; i++) begin
            eng_dout[i] = 54'd0;
            eng_st[i] = 0;
            eng_cnt[i] = 0;
        end
        forever begin
            @(negedge clock);
            s_start = eng_start; s_ready = eng_ready; s_dack = eng_done_ack;
            s_valid = eng_valid; s_reset = reset;
            @(posedge clock);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (s_reset) begin
                    eng_st[i] = 0; eng_cnt[i] = 0;
                    eng_start_ack[i] = 1'b0; eng_valid[i] = 1'b0; eng_done[i] = 1'b0;
                end else begin
                    case (eng_st[i])
                        0: if (s_start[i] && ack_en[i]) begin
                            eng_start_ack[i] = 1'b1; eng_st[i] = 1;
                        end
                        1: begin
                            eng_start_ack[i] = 1'b0; eng_cnt[i] = 0;
                            eng_dout[i] = mkword((i == 1) ? 1 : 0, 0);
                            eng_valid[i] = 1'b1; eng_st[i] = 2;
                        end
                        2: if (s_valid[i] && s_ready[i]) begin
                            eng_cnt[i]++;
                            if (eng_cnt[i] == NW) begin
                                eng_valid[i] = 1'b0; eng_done[i] = 1'b1; eng_st[i] = 3;
                            end else begin
                                eng_dout[i] = mkword((i == 1) ? 1 : 0, eng_cnt[i]);
                            end
                        end
                        3: if (s_dack[i]) begin
                            eng_done[i] = 1'b0; eng_st[i] = 0;
                        end
                        default: eng_st[i] = 0;
                    endcase
                end
            end
            wr_ready = bp ? ~wr_ready : 1'b1;
        end
    end

    // Monitor: counts transfers and records event cycles at each negedge.
    int cyc = 0;
    int a_cnt, a_bad, a_gap, a_last_x, a_fd_cnt, a_fd_cyc, a_d0_cyc, a_d1_cyc, a_s1_cyc;
    int a_s0_hi, a_s1_hi, a_dack0, a_dack1;
    int b_cnt, b_bad, b_fd_cnt, b_fd_cyc, b_d0_cyc, b_s1_seen;
    logic [2:0] p_done = 3'b0;
    logic p_s1 = 1'b0;
    initial begin
        int idx;
        forever begin
            @(negedge clock);
            cyc++;
            if (a_wr_valid && wr_ready) begin
                idx = a_cnt % (2 * NW);
                if (a_wr_dout !== mkword(idx / NW, idx % NW)) a_bad++;
                if ((idx % NW) != 0 && a_last_x != cyc - 1 && !bp) a_gap++;
                a_last_x = cyc;
                a_cnt++;
            end
            if (eng_done[0] && !p_done[0]) a_d0_cyc = cyc;
            if (eng_done[1] && !p_done[1]) a_d1_cyc = cyc;
            if (a_e1_start && !p_s1) a_s1_cyc = cyc;
            if (a_e0_start) a_s0_hi++;
            if (a_e1_start) a_s1_hi++;
            if (a_e0_done_ack) a_dack0++;
            if (a_e1_done_ack) a_dack1++;
            if (a_frame_done) begin a_fd_cnt++; a_fd_cyc = cyc; end
            if (b_wr_valid && wr_ready) begin
                if (b_wr_dout !== mkword(0, b_cnt % NW)) b_bad++;
                b_cnt++;
            end
            if (eng_done[2] && !p_done[2]) b_d0_cyc = cyc;
            if (b_frame_done) begin b_fd_cnt++; b_fd_cyc = cyc; end
            if (b_e1_start) b_s1_seen++;
            p_done = eng_done;
            p_s1 = a_e1_start;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_counters();
        a_cnt = 0; a_bad = 0; a_gap = 0; a_last_x = 0; a_fd_cnt = 0; a_fd_cyc = 0;
        a_d0_cyc = 0; a_d1_cyc = 0; a_s1_cyc = 0; a_s0_hi = 0; a_s1_hi = 0;
        a_dack0 = 0; a_dack1 = 0;
        b_cnt = 0; b_bad = 0; b_fd_cnt = 0; b_fd_cyc = 0; b_d0_cyc = 0; b_s1_seen = 0;
    endtask

    task automatic pulse_a();
        @(posedge clock); #1 a_frame_start = 1'b1;
        @(posedge clock); #1 a_frame_start = 1'b0;
    endtask

    task automatic wait_a_frames(input int n);
        for (int k = 0; k < 2000 && a_fd_cnt < n; k++) tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({a_busy, a_e0_start, a_e1_start, a_e0_done_ack, a_e1_done_ack, a_e0_ready,
             a_e1_ready, a_wr_valid, a_frame_done, a_timeout_err, a_overrun} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs_a: busy=%0b start=%0b%0b wr_valid=%0b want all 0",
                     a_busy, a_e0_start, a_e1_start, a_wr_valid);
        end
        checks++;
        if (a_frame_count !== 16'd0 || b_frame_count !== 16'd0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_counts: a=%0d b=%0d b_busy=%0b want 0 0 0",
                     a_frame_count, b_frame_count, b_busy);
        end
        @(posedge clock); #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        clear_counters();
        pulse_a();
        tick();
        checks++;
        if (a_e0_start !== 1'b1) begin
            errors++; $display("FAIL start_latency: e0_start=%0b want 1", a_e0_start);
        end
        wait_a_frames(1);
        checks++;
        if (a_fd_cnt !== 1) begin
            errors++; $display("FAIL nominal_frame_done: got %0d want 1", a_fd_cnt);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_frame_count !== 16'd1) begin
            errors++;
            $display("FAIL nominal_end: busy=%0b count=%0d want 0 1", a_busy, a_frame_count);
        end
        repeat (5) tick();
        checks++;
        if (a_cnt !== 2 * NW || a_bad !== 0 || a_gap !== 0) begin
            errors++;
            $display("FAIL nominal_words: count=%0d bad=%0d gaps=%0d want 128 0 0",
                     a_cnt, a_bad, a_gap);
        end
        checks++;
        if (a_s0_hi !== 2) begin
            errors++; $display("FAIL start_width: got %0d cycles want 2", a_s0_hi);
        end
        checks++;
        if (a_s1_cyc - a_d0_cyc !== 2) begin
            errors++; $display("FAIL handoff: e0_done->e1_start %0d want 2", a_s1_cyc - a_d0_cyc);
        end
        checks++;
        if (a_fd_cyc - a_d1_cyc !== 2) begin
            errors++;
            $display("FAIL frame_end: e1_done->frame_done %0d want 2", a_fd_cyc - a_d1_cyc);
        end
        checks++;
        if (a_dack0 !== 1 || a_dack1 !== 1 || a_fd_cnt !== 1) begin
            errors++;
            $display("FAIL pulse_counts: dack0=%0d dack1=%0d frame_done=%0d want 1 1 1",
                     a_dack0, a_dack1, a_fd_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_counters();
        bp = 1'b1;
        pulse_a();
        wait_a_frames(1);
        repeat (3) tick();
        bp = 1'b0;
        checks++;
        if (a_cnt !== 2 * NW || a_bad !== 0) begin
            errors++;
            $display("FAIL bp_words: count=%0d bad=%0d want 128 0", a_cnt, a_bad);
        end
        checks++;
        if (a_frame_count !== 16'd2 || a_fd_cnt !== 1) begin
            errors++;
            $display("FAIL bp_frames: count=%0d pulses=%0d want 2 1", a_frame_count, a_fd_cnt);
        end
    endtask

    task automatic test_no_overlay();
        clear_counters();
        @(posedge clock); #1 b_frame_start = 1'b1;
        @(posedge clock); #1 b_frame_start = 1'b0;
        for (int k = 0; k < 1000 && b_fd_cnt < 1; k++) tick();
        repeat (5) tick();
        checks++;
        if (b_cnt !== NW || b_bad !== 0) begin
            errors++; $display("FAIL noov_words: count=%0d bad=%0d want 64 0", b_cnt, b_bad);
        end
        checks++;
        if (b_s1_seen !== 0 || b_e1_done_ack !== 1'b0 || b_e1_ready !== 1'b0) begin
            errors++; $display("FAIL noov_e1_start: e1_start cycles=%0d want 0", b_s1_seen);
        end
        checks++;
        if (b_fd_cyc - b_d0_cyc !== 2 || b_fd_cnt !== 1) begin
            errors++;
            $display("FAIL noov_timing: done->frame_done %0d pulses %0d want 2 1",
                     b_fd_cyc - b_d0_cyc, b_fd_cnt);
        end
        checks++;
        if (b_frame_count !== 16'd1 || b_busy !== 1'b0 || b_timeout_err !== 1'b0
            || b_overrun !== 1'b0) begin
            errors++;
            $display("FAIL noov_status: count=%0d busy=%0b want 1 0", b_frame_count, b_busy);
        end
    endtask

    task automatic test_pending_overrun();
        clear_counters();
        pulse_a();
        repeat (5) tick();
        pulse_a();
        repeat (5) tick();
        checks++;
        if (a_overrun !== 1'b0) begin
            errors++; $display("FAIL single_queue: overrun=%0b want 0", a_overrun);
        end
        pulse_a();
        repeat (5) tick();
        pulse_a();
        wait_a_frames(2);
        repeat (20) tick();
        checks++;
        if (a_fd_cnt !== 2 || a_frame_count !== 16'd4) begin
            errors++;
            $display("FAIL pending_frames: pulses=%0d count=%0d want 2 4", a_fd_cnt, a_frame_count);
        end
        checks++;
        if (a_overrun !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_flag: overrun=%0b busy=%0b want 1 0", a_overrun, a_busy);
        end
        checks++;
        if (a_cnt !== 4 * NW || a_bad !== 0) begin
            errors++; $display("FAIL pending_words: count=%0d bad=%0d want 256 0", a_cnt, a_bad);
        end
    endtask

    task automatic test_timeout();
        clear_counters();
        ack_en[1] = 1'b0;
        pulse_a();
        for (int k = 0; k < 1000 && a_timeout_err !== 1'b1; k++) tick();
        checks++;
        if (a_timeout_err !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: err=%0b busy=%0b want 1 0", a_timeout_err, a_busy);
        end
        repeat (10) tick();
        ack_en[1] = 1'b1;
        checks++;
        if (a_s1_hi !== 4) begin
            errors++; $display("FAIL timeout_width: e1_start cycles=%0d want 4", a_s1_hi);
        end
        checks++;
        if (a_fd_cnt !== 0 || a_frame_count !== 16'd4 || a_cnt !== NW) begin
            errors++;
            $display("FAIL timeout_no_done: pulses=%0d count=%0d words=%0d want 0 4 64",
                     a_fd_cnt, a_frame_count, a_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_counters();
        pulse_a();
        for (int k = 0; k < 100 && a_e0_ready !== 1'b1; k++) tick();
        repeat (5) tick();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        tick();
        checks++;
        if ({a_busy, a_e0_start, a_e1_start, a_e0_done_ack, a_e1_done_ack, a_e0_ready,
             a_e1_ready, a_wr_valid, a_frame_done, a_timeout_err, a_overrun} !== 11'b0
            || a_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%0b e0_ready=%0b wr_valid=%0b err=%0b count=%0d",
                     a_busy, a_e0_ready, a_wr_valid, a_timeout_err, a_frame_count);
        end
        clear_counters();
        pulse_a();
        wait_a_frames(1);
        repeat (5) tick();
        checks++;
        if (a_cnt !== 2 * NW || a_bad !== 0 || a_frame_count !== 16'd1) begin
            errors++;
            $display("FAIL midreset_recover: words=%0d bad=%0d count=%0d want 128 0 1",
                     a_cnt, a_bad, a_frame_count);
        end
    endtask

    initial begin
        clear_counters();
        test_reset();
        test_nominal();
        test_backpressure();
        test_no_overlay();
        test_pending_overrun();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
